ddr_cmd_scheduler: RTL and testbench

//  Turns single-beat read/write requests into legal DDR3 ACT/RD/WR/PRE/REF command sequences.

---
 rtl/ddr_cmd_pkg.sv | 70 +++++++
 rtl/ddr_cmd_scheduler_if.sv | 46 ++++
 rtl/ddr_bank_tracker.sv | 78 +++++++
 rtl/ddr_cmd_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_cmd_pkg.sv
// Shared definitions for the DDR3 command scheduler: command-word layout,
// pin/phy encodings, internal command and FSM state enums.
package ddr_cmd_pkg;

  localparam int CMD_W      = 11;
  localparam int PINS_LSB   = 0;   // {cs_n, we_n, cas_n, ras_n}
  localparam int PHY_LSB    = 4;
  localparam int WRDATA_BIT = 7;
  localparam int BANKV_BIT  = 8;
  localparam int SEL_LSB    = 9;

  localparam logic [3:0] PINS_ACT = 4'h6;
  localparam logic [3:0] PINS_RD  = 4'h5;
  localparam logic [3:0] PINS_WR  = 4'h1;
  localparam logic [3:0] PINS_PRE = 4'h2;
  localparam logic [3:0] PINS_REF = 4'h4;
  localparam logic [3:0] PINS_NOP = 4'hF;

  localparam logic [2:0] PHY_WR   = 3'd0;
  localparam logic [2:0] PHY_RD   = 3'd1;
  localparam logic [2:0] PHY_CTRL = 3'd4;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_ROW  = 2'b01;
  localparam logic [1:0] SEL_COL  = 2'b10;
  localparam logic [1:0] SEL_A10  = 2'b11;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_PREA, CMD_REF
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_ACT, ST_WAIT, ST_RW, ST_PREA, ST_REF, ST_RFC
  } state_e;

  // Timers hold the number of blocked cycles after the issuing cycle, so a
  // command gated by delay T may issue exactly T cycles after its predecessor.
  function automatic int tmr_load(input int t);
    return (t > 0) ? t - 1 : 0;
  endfunction

  function automatic logic [CMD_W-1:0] cmd_word(input cmd_e c);
    logic [3:0] pins;
    logic [2:0] phy;
    logic       wd;
    logic       bv;
    logic [1:0] sel;
    pins = PINS_NOP;
    phy  = PHY_CTRL;
    wd   = 1'b0;
    bv   = 1'b0;
    sel  = SEL_ZERO;
    case (c)
      CMD_ACT:  begin pins = PINS_ACT; bv = 1'b1; sel = SEL_ROW; end
      CMD_RD:   begin pins = PINS_RD; phy = PHY_RD; bv = 1'b1; sel = SEL_COL; end
      CMD_WR:   begin pins = PINS_WR; phy = PHY_WR; wd = 1'b1; bv = 1'b1; sel = SEL_COL; end
      CMD_PRE:  begin pins = PINS_PRE; bv = 1'b1; end
      CMD_PREA: begin pins = PINS_PRE; sel = SEL_A10; end
      CMD_REF:  begin pins = PINS_REF; end
      default:  ;
    endcase
    cmd_word                   = '0;
    cmd_word[PINS_LSB +: 4]    = pins;
    cmd_word[PHY_LSB +: 3]     = phy;
    cmd_word[WRDATA_BIT]       = wd;
    cmd_word[BANKV_BIT]        = bv;
    cmd_word[SEL_LSB +: 2]     = sel;
  endfunction

endpackage

// File: rtl/ddr_cmd_scheduler_if.sv
// Request channel and command bus between requester, scheduler and the
// downstream command loader.
// Handshake: a request transfers on a cycle where req_valid and req_ready are
// both high; the requester holds all req_* fields stable while req_valid waits.
interface ddr_cmd_scheduler_if #(
  parameter int BA_BITS   = 3,
  parameter int ROW_BITS  = 14,
  parameter int COL_BITS  = 10,
  parameter int SLOT_BITS = 2
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [BA_BITS-1:0]   req_bank;
  logic [ROW_BITS-1:0]  req_row;
  logic [COL_BITS-1:0]  req_col;
  logic                 ref_req;
  logic                 ref_ack;

  logic                 cmd_valid;
  logic [SLOT_BITS-1:0] cmd_slot;
  logic [10:0]          active_cmd;
  logic [BA_BITS-1:0]   bank;
  logic [ROW_BITS-1:0]  row;
  logic [COL_BITS-1:0]  col;
  logic                 ap_bit;
  logic                 auto_precharge;
  logic                 auto_activate;
  logic [BA_BITS-1:0]   selected_auto_precharge_bank;
  logic [BA_BITS-1:0]   auto_activate_bank;
  logic [ROW_BITS-1:0]  auto_activate_row;

  modport master (
    output req_valid, req_write, req_bank, req_row, req_col, ref_req,
    input  req_ready, ref_ack, cmd_valid, cmd_slot, active_cmd, bank, row, col,
    input  ap_bit, auto_precharge, auto_activate, selected_auto_precharge_bank,
    input  auto_activate_bank, auto_activate_row
  );

  modport slave (
    input  req_valid, req_write, req_bank, req_row, req_col, ref_req,
    output req_ready, ref_ack, cmd_valid, cmd_slot, active_cmd, bank, row, col,
    output ap_bit, auto_precharge, auto_activate, selected_auto_precharge_bank,
    output auto_activate_bank, auto_activate_row
  );
endinterface

// File: rtl/ddr_bank_tracker.sv
// Per-bank open flag, open row and precharge-blocking timer (tRAS/tWR/tRTP),
// with a lookup port used to classify an incoming request as hit/closed/miss.
module ddr_bank_tracker
  import ddr_cmd_pkg::*;
#(
  parameter int BA_BITS  = 3,
  parameter int ROW_BITS = 14,
  parameter int TMR_BITS = 5,
  parameter int T_RAS    = 5,
  parameter int T_WR     = 4,
  parameter int T_RTP    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     act_en,
  input  logic                     pre_en,
  input  logic                     prea_en,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [BA_BITS-1:0]       cmd_bank,
  input  logic [ROW_BITS-1:0]      cmd_row,
  input  logic [BA_BITS-1:0]       look_bank,
  input  logic [ROW_BITS-1:0]      look_row,
  output logic                     look_open,
  output logic                     look_hit,
  output logic [(2**BA_BITS)-1:0]  pre_clear,
  output logic                     any_open,
  output logic                     all_pre_clear
);
  localparam int NB = 2**BA_BITS;
  localparam logic [TMR_BITS-1:0] LD_RAS = TMR_BITS'(tmr_load(T_RAS));
  localparam logic [TMR_BITS-1:0] LD_WR  = TMR_BITS'(tmr_load(T_WR));
  localparam logic [TMR_BITS-1:0] LD_RTP = TMR_BITS'(tmr_load(T_RTP));

  logic [NB-1:0] open_vec;
  logic [NB-1:0] hit_vec;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic                sel;
    logic                open_r;
    logic [ROW_BITS-1:0] row_r;
    logic [TMR_BITS-1:0] blk_r;
    logic [TMR_BITS-1:0] blk_dec;

    assign sel     = (cmd_bank == BA_BITS'(b));
    assign blk_dec = (blk_r == '0) ? '0 : blk_r - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        open_r <= 1'b0;
        row_r  <= '0;
        blk_r  <= '0;
      end else begin
        if (prea_en || (pre_en && sel)) begin
          open_r <= 1'b0;
        end else if (act_en && sel) begin
          open_r <= 1'b1;
          row_r  <= cmd_row;
        end
        // A read only extends the window; it must never shorten tRAS/tWR.
        if (act_en && sel)      blk_r <= LD_RAS;
        else if (wr_en && sel)  blk_r <= LD_WR;
        else if (rd_en && sel)  blk_r <= (blk_dec > LD_RTP) ? blk_dec : LD_RTP;
        else                    blk_r <= blk_dec;
      end
    end

    assign open_vec[b]  = open_r;
    assign hit_vec[b]   = open_r && (row_r == look_row);
    assign pre_clear[b] = (blk_r == '0);
  end

  assign look_open     = open_vec[look_bank];
  assign look_hit      = hit_vec[look_bank];
  assign any_open      = |open_vec;
  assign all_pre_clear = &pre_clear;

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// Converts single-beat read/write requests and refresh requests into DDR3
// ACT/RD/WR/PRE/PREA/REF commands with open-page policy and timing gating.
module ddr_cmd_scheduler
  import ddr_cmd_pkg::*;
#(
  parameter int BA_BITS   = 3,
  parameter int ROW_BITS  = 14,
  parameter int COL_BITS  = 10,
  parameter int SLOT_BITS = 2,
  parameter int CMD_SLOT  = 0,
  parameter int TMR_BITS  = 5,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2,
  parameter int T_RAS     = 5,
  parameter int T_WR      = 4,
  parameter int T_RTP     = 1,
  parameter int T_RFC     = 28
) (
  input  logic            clk,
  input  logic            rst_n,
  ddr_cmd_scheduler_if.slave bus,
  output logic            busy,
  output state_e          dbg_state
);
  localparam int NB = 2**BA_BITS;
  localparam logic [TMR_BITS-1:0] LD_RCD = TMR_BITS'(tmr_load(T_RCD));
  localparam logic [TMR_BITS-1:0] LD_RP  = TMR_BITS'(tmr_load(T_RP));
  localparam logic [TMR_BITS-1:0] LD_RFC = TMR_BITS'(tmr_load(T_RFC));
  localparam logic [TMR_BITS-1:0] ONE    = TMR_BITS'(1);

  state_e              state_q, state_d;
  cmd_e                cmd;
  logic                ready;
  logic                accept;
  logic                out_of_reset_q;
  logic                ref_pending_q;
  logic                lat_write_q;
  logic [BA_BITS-1:0]  lat_bank_q;
  logic [ROW_BITS-1:0] lat_row_q;
  logic [COL_BITS-1:0] lat_col_q;
  logic [TMR_BITS-1:0] act_blk_q, rp_blk_q, rfc_q;
  logic                look_open, look_hit, any_open, all_pre_clear;
  logic [NB-1:0]       pre_clear;

  function automatic logic [TMR_BITS-1:0] dec_sat(input logic [TMR_BITS-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  ddr_bank_tracker #(
    .BA_BITS (BA_BITS),
    .ROW_BITS(ROW_BITS),
    .TMR_BITS(TMR_BITS),
    .T_RAS   (T_RAS),
    .T_WR    (T_WR),
    .T_RTP   (T_RTP)
  ) u_banks (
    .clk          (clk),
    .rst_n        (rst_n),
    .act_en       (cmd == CMD_ACT),
    .pre_en       (cmd == CMD_PRE),
    .prea_en      (cmd == CMD_PREA),
    .wr_en        (cmd == CMD_WR),
    .rd_en        (cmd == CMD_RD),
    .cmd_bank     (lat_bank_q),
    .cmd_row      (lat_row_q),
    .look_bank    (bus.req_bank),
    .look_row     (bus.req_row),
    .look_open    (look_open),
    .look_hit     (look_hit),
    .pre_clear    (pre_clear),
    .any_open     (any_open),
    .all_pre_clear(all_pre_clear)
  );

  // Commands are decoded from registered state only, so an asynchronous
  // reset collapses the bus to NOP in the same cycle.
  always_comb begin
    state_d = state_q;
    cmd     = CMD_NONE;
    ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ref_pending_q) begin
          state_d = any_open ? ST_PREA : ST_REF;
        end else if (out_of_reset_q) begin
          ready = 1'b1;
          if (bus.req_valid) begin
            if (look_hit)       state_d = ST_RW;
            else if (look_open) state_d = ST_PRE;
            else                state_d = ST_ACT;
          end
        end
      end
      ST_PRE: begin
        if (pre_clear[lat_bank_q]) begin
          cmd     = CMD_PRE;
          state_d = ST_ACT;
        end
      end
      ST_ACT: begin
        if (rp_blk_q == '0) begin
          cmd     = CMD_ACT;
          state_d = ST_WAIT;
        end
      end
      // Leave one cycle early: act_blk reaches zero as RW is entered.
      ST_WAIT: begin
        if (act_blk_q <= ONE) state_d = ST_RW;
      end
      ST_RW: begin
        if (act_blk_q == '0) begin
          cmd     = lat_write_q ? CMD_WR : CMD_RD;
          state_d = ST_IDLE;
        end
      end
      ST_PREA: begin
        if (all_pre_clear) begin
          cmd     = CMD_PREA;
          state_d = ST_REF;
        end
      end
      ST_REF: begin
        if (rp_blk_q == '0) begin
          cmd     = CMD_REF;
          state_d = ST_RFC;
        end
      end
      ST_RFC: begin
        if (rfc_q <= ONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = bus.req_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      out_of_reset_q <= 1'b0;
      ref_pending_q  <= 1'b0;
      lat_write_q    <= 1'b0;
      lat_bank_q     <= '0;
      lat_row_q      <= '0;
      lat_col_q      <= '0;
      act_blk_q      <= '0;
      rp_blk_q       <= '0;
      rfc_q          <= '0;
    end else begin
      state_q        <= state_d;
      out_of_reset_q <= 1'b1;
      if (accept) begin
        lat_write_q <= bus.req_write;
        lat_bank_q  <= bus.req_bank;
        lat_row_q   <= bus.req_row;
        lat_col_q   <= bus.req_col;
      end
      act_blk_q <= (cmd == CMD_ACT) ? LD_RCD : dec_sat(act_blk_q);
      rp_blk_q  <= (cmd == CMD_PRE || cmd == CMD_PREA) ? LD_RP : dec_sat(rp_blk_q);
      rfc_q     <= (cmd == CMD_REF) ? LD_RFC : dec_sat(rfc_q);
      // Pulses arriving while a refresh is already pending merge into it.
      if (cmd == CMD_REF)   ref_pending_q <= 1'b0;
      else if (bus.ref_req) ref_pending_q <= 1'b1;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.ref_ack    = (cmd == CMD_REF);
  assign bus.cmd_valid  = (cmd != CMD_NONE);
  assign bus.cmd_slot   = SLOT_BITS'(CMD_SLOT);
  assign bus.active_cmd = cmd_word(cmd);
  assign bus.bank       = (cmd == CMD_ACT || cmd == CMD_RD || cmd == CMD_WR || cmd == CMD_PRE)
                          ? lat_bank_q : '0;
  assign bus.row        = (cmd == CMD_ACT) ? lat_row_q : '0;
  assign bus.col        = (cmd == CMD_RD || cmd == CMD_WR) ? lat_col_q : '0;
  assign bus.ap_bit                       = 1'b0;
  assign bus.auto_precharge               = 1'b0;
  assign bus.auto_activate                = 1'b0;
  assign bus.selected_auto_precharge_bank = '0;
  assign bus.auto_activate_bank           = '0;
  assign bus.auto_activate_row            = '0;

  assign busy      = (state_q != ST_IDLE) || any_open || ref_pending_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: command sequences, timing gaps,
// refresh handling and asynchronous reset, checked against hand-computed values.
module tb_ddr_cmd_scheduler;
  import ddr_cmd_pkg::*;

  localparam logic [10:0] W_NOP  = 11'h04F;
  localparam logic [10:0] W_ACT  = 11'h346;
  localparam logic [10:0] W_RD   = 11'h515;
  localparam logic [10:0] W_WR   = 11'h581;
  localparam logic [10:0] W_PRE  = 11'h142;
  localparam logic [10:0] W_PREA = 11'h642;
  localparam logic [10:0] W_REF  = 11'h044;
  localparam int T_RCD = 2;
  localparam int T_RP  = 2;
  localparam int T_RAS = 5;
  localparam int T_WR  = 4;
  localparam int T_RFC = 28;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   busy;
  state_e dbg_state;
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;

  ddr_cmd_scheduler_if bus ();

  ddr_cmd_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present a request, wait for transfer, return on the cycle after it
  task automatic send_req(input logic w, input logic [2:0] b, input logic [13:0] r,
                          input logic [9:0] c, input logic with_ref, output int acc);
    int guard;
    guard = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_bank  = b;
    bus.req_row   = r;
    bus.req_col   = c;
    bus.ref_req   = with_ref;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_accept_in_time", guard < 50, 1);
    acc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.ref_req   = 1'b0;
  endtask

  task automatic wait_cmd(input int limit, output int at, output logic [10:0] word);
    at   = -1;
    word = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.cmd_valid) begin
        at   = cyc;
        word = bus.active_cmd;
        break;
      end
    end
  endtask

  initial begin
    int n, at, wr_at, pre_at, act_at, act5_at, prea_at, ref_at, rd_at, nref, nvalid;
    logic [10:0] w;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_bank  = '0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.ref_req   = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_active_cmd", bus.active_cmd, W_NOP);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_ref_ack", bus.ref_ack, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // read to a closed bank: ACT at N+1, RD at N+1+T_RCD
    send_req(1'b0, 3'd2, 14'h100, 10'h010, 1'b0, n);
    check("t1_act_valid", bus.cmd_valid, 1);
    check("t1_act_word", bus.active_cmd, W_ACT);
    check("t1_act_bank", bus.bank, 2);
    check("t1_act_row", bus.row, 14'h100);
    check("t1_cmd_slot", bus.cmd_slot, 0);
    check("t1_fixed_zero", {bus.ap_bit, bus.auto_precharge, bus.auto_activate,
          bus.selected_auto_precharge_bank, bus.auto_activate_bank, bus.auto_activate_row}, 0);
    @(negedge clk);
    check("t1_wait_nop", {bus.cmd_valid, bus.active_cmd}, {1'b0, W_NOP});
    @(negedge clk);
    check("t1_rd_cycle", cyc, n + 1 + T_RCD);
    check("t1_rd_word", bus.active_cmd, W_RD);
    check("t1_rd_addr", {bus.bank, bus.col}, {3'd2, 10'h010});
    @(negedge clk);
    check("t1_ready_after_rd", bus.req_ready, 1);
    check("t1_busy_bank_open", busy, 1);

    // row hit: RD directly at N+1
    send_req(1'b0, 3'd2, 14'h100, 10'h020, 1'b0, n);
    check("t2_hit_rd_word", {bus.cmd_valid, bus.active_cmd}, {1'b1, W_RD});
    check("t2_hit_rd_col", bus.col, 10'h020);
    @(negedge clk);
    check("t2_ready_after_rd", bus.req_ready, 1);

    // write hit, then write miss to another row of the same bank
    send_req(1'b1, 3'd2, 14'h100, 10'h030, 1'b0, n);
    wr_at = cyc;
    w = bus.active_cmd;
    check("t3_wr_word", w, W_WR);
    check("t3_wrdata_en", w[7], 1);
    send_req(1'b1, 3'd2, 14'h200, 10'h040, 1'b0, n);
    check("t3_pre_blocked", bus.cmd_valid, 0);
    wait_cmd(20, pre_at, w);
    check("t3_pre_word", w, W_PRE);
    check("t3_pre_bank", bus.bank, 2);
    check("t3_pre_after_twr", (pre_at - wr_at) >= T_WR, 1);
    check("t3_pre_cycle", pre_at, wr_at + T_WR);
    wait_cmd(20, act_at, w);
    check("t3_act_word", w, W_ACT);
    check("t3_act_gap_trp", act_at - pre_at, T_RP);
    check("t3_act_row", bus.row, 14'h200);
    wait_cmd(20, at, w);
    check("t3_wr2_word", w, W_WR);
    check("t3_wr2_gap_trcd", at - act_at, T_RCD);
    check("t3_wr2_wrdata_en", w[7], 1);
    check("t3_wr2_col", bus.col, 10'h040);

    // open banks 0 and 5, then refresh
    send_req(1'b0, 3'd0, 14'h010, 10'h001, 1'b0, n);
    check("t4_act_b0", {bus.active_cmd, bus.bank}, {W_ACT, 3'd0});
    wait_cmd(10, at, w);
    check("t4_rd_b0", w, W_RD);
    send_req(1'b0, 3'd5, 14'h050, 10'h005, 1'b0, n);
    act5_at = cyc;
    check("t4_act_b5", {bus.active_cmd, bus.bank}, {W_ACT, 3'd5});
    wait_cmd(10, rd_at, w);
    check("t4_rd_b5", w, W_RD);
    check("t4_rd_b5_cycle", rd_at, act5_at + T_RCD);
    bus.ref_req = 1'b1;
    @(negedge clk);
    bus.ref_req = 1'b0;
    check("t4_ready_blocked", bus.req_ready, 0);
    wait_cmd(40, prea_at, w);
    check("t4_prea_word", w, W_PREA);
    check("t4_prea_a10_sel", w[10:9], 2'b11);
    check("t4_prea_after_tras", (prea_at - act5_at) >= T_RAS, 1);
    check("t4_prea_cycle", prea_at, act5_at + T_RAS);
    wait_cmd(10, ref_at, w);
    check("t4_ref_word", w, W_REF);
    check("t4_ref_gap_trp", ref_at - prea_at, T_RP);
    check("t4_ref_ack_high", bus.ref_ack, 1);
    @(negedge clk);
    check("t4_ref_ack_pulse", bus.ref_ack, 0);
    for (int i = 0; i < 100 && !bus.req_ready; i++) @(negedge clk);
    check("t4_rfc_ready_len", cyc - ref_at, T_RFC);
    check("t4_busy_idle", busy, 0);

    // ref_req together with a transfer, plus a second merged pulse
    send_req(1'b0, 3'd1, 14'h111, 10'h007, 1'b1, n);
    check("t5_act_word", bus.active_cmd, W_ACT);
    rd_at = -1; prea_at = -1; ref_at = -1; nref = 0;
    bus.ref_req = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      bus.ref_req = 1'b0;
      if (bus.cmd_valid && bus.active_cmd == W_RD && rd_at < 0) rd_at = cyc;
      if (bus.cmd_valid && bus.active_cmd == W_PREA && prea_at < 0) prea_at = cyc;
      if (bus.cmd_valid && bus.active_cmd == W_REF) begin
        if (ref_at < 0) ref_at = cyc;
        nref++;
      end
    end
    check("t5_rd_cycle", rd_at, n + 1 + T_RCD);
    check("t5_rd_before_prea", (rd_at >= 0) && (prea_at > rd_at), 1);
    check("t5_ref_gap_trp", ref_at - prea_at, T_RP);
    check("t5_single_ref", nref, 1);

    // asynchronous reset while waiting on tRCD
    send_req(1'b0, 3'd3, 14'h033, 10'h003, 1'b0, n);
    check("t6_act_word", bus.active_cmd, W_ACT);
    @(negedge clk);
    check("t6_in_wait", dbg_state, ST_WAIT);
    rst_n = 1'b0;
    #1;
    check("t6_rst_cmd", {bus.cmd_valid, bus.active_cmd}, {1'b0, W_NOP});
    check("t6_rst_state", dbg_state, ST_IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cmd_valid) nvalid++;
    end
    check("t6_no_cmd_after_rst", nvalid, 0);
    check("t6_busy_after_rst", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
